// File: rtl/reg_bank.sv
// reg_bank: DEPTH x WIDTH flip-flop register bank with one synchronous write port and
// two independent registered read ports. Define RB_BYPASS_EN for write-first same-edge reads.
module reg_bank #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re_a,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [WIDTH-1:0]  rdata_a,
  output logic              rvalid_a,
  input  logic              re_b,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [WIDTH-1:0]  rdata_b,
  output logic              rvalid_b
);

  // One extra bit so the depth itself is representable for range checks.
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic             w_ok;
  logic             a_ok;
  logic             b_ok;
  logic [WIDTH-1:0] rd_a;
  logic [WIDTH-1:0] rd_b;

  assign w_ok = ({1'b0, waddr} < DEPTH_L);
  assign a_ok = ({1'b0, raddr_a} < DEPTH_L);
  assign b_ok = ({1'b0, raddr_b} < DEPTH_L);

  // Read handshake: a request sampled with re=1 yields rdata plus rvalid=1 on the next
  // cycle; with re=0 rvalid drops and rdata keeps its last value. There is no backpressure.
  always_comb begin
    rd_a = '0;
    if (a_ok) rd_a = mem[raddr_a];
`ifdef RB_BYPASS_EN
    if (we && w_ok && (raddr_a == waddr)) rd_a = wdata;
`endif
  end

  always_comb begin
    rd_b = '0;
    if (b_ok) rd_b = mem[raddr_b];
`ifdef RB_BYPASS_EN
    if (we && w_ok && (raddr_b == waddr)) rd_b = wdata;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rdata_a  <= '0;
      rvalid_a <= 1'b0;
      rdata_b  <= '0;
      rvalid_b <= 1'b0;
    end else begin
      if (we && w_ok) mem[waddr] <= wdata;
      if (re_a) rdata_a <= rd_a;
      rvalid_a <= re_a;
      if (re_b) rdata_b <= rd_b;
      rvalid_b <= re_b;
    end
  end

endmodule

// File: tb/tb_reg_bank.sv
// tb_reg_bank: directed bench for reg_bank at DEPTH=6, WIDTH=16 with a per-cycle
// behavioural model plus hand-computed literal expectations.
module tb_reg_bank;

  localparam int W = 16;
  localparam int D = 6;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          we = 1'b0;
  logic [AW-1:0] waddr = '0;
  logic [W-1:0]  wdata = '0;
  logic          re_a = 1'b0;
  logic [AW-1:0] raddr_a = '0;
  logic [W-1:0]  rdata_a;
  logic          rvalid_a;
  logic          re_b = 1'b0;
  logic [AW-1:0] raddr_b = '0;
  logic [W-1:0]  rdata_b;
  logic          rvalid_b;

  int n_cmp = 0;
  int n_err = 0;

  reg_bank #(.WIDTH(W), .DEPTH(D)) u_dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .re_a(re_a), .raddr_a(raddr_a), .rdata_a(rdata_a), .rvalid_a(rvalid_a),
    .re_b(re_b), .raddr_b(raddr_b), .rdata_b(rdata_b), .rvalid_b(rvalid_b)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: an array of words plus the last value returned per port.
  logic [W-1:0] m_mem [D];
  logic [W-1:0] m_rd_a = '0;
  logic [W-1:0] m_rd_b = '0;
  logic         m_rv_a = 1'b0;
  logic         m_rv_b = 1'b0;
  bit           m_live = 1'b0;

  function automatic logic [W-1:0] m_read(input logic [AW-1:0] a);
    logic [W-1:0] v;
    v = '0;
    if (int'(a) < D) v = m_mem[a];
`ifdef RB_BYPASS_EN
    if (we && int'(waddr) < D && waddr == a) v = wdata;
`endif
    return v;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < D; i++) m_mem[i] = '0;
      m_rd_a = '0; m_rd_b = '0; m_rv_a = 1'b0; m_rv_b = 1'b0;
      m_live = 1'b1;
    end else begin
      if (re_a) m_rd_a = m_read(raddr_a);
      if (re_b) m_rd_b = m_read(raddr_b);
      m_rv_a = re_a;
      m_rv_b = re_b;
      if (we && int'(waddr) < D) m_mem[waddr] = wdata;
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_live) begin
      check("cyc_rdata_a", rdata_a, m_rd_a);
      check("cyc_rvalid_a", W'(rvalid_a), W'(m_rv_a));
      check("cyc_rdata_b", rdata_b, m_rd_b);
      check("cyc_rvalid_b", W'(rvalid_b), W'(m_rv_b));
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; we = 1'b0; re_a = 1'b0; re_b = 1'b0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [W-1:0] d);
    idle();
    we = 1'b1; waddr = a; wdata = d;
    tick();
    we = 1'b0;
  endtask

  task automatic rd2(input logic [AW-1:0] a, input logic [AW-1:0] b);
    idle();
    re_a = 1'b1; raddr_a = a; re_b = 1'b1; raddr_b = b;
    tick();
  endtask

  logic [W-1:0] final_tbl [D];
  logic [W-1:0] coll_exp;

  initial begin
    final_tbl[0] = 16'h0000; final_tbl[1] = 16'h0000; final_tbl[2] = 16'h0077;
    final_tbl[3] = 16'h003C; final_tbl[4] = 16'h0000; final_tbl[5] = 16'h00C3;
`ifdef RB_BYPASS_EN
    coll_exp = 16'h0077;
`else
    coll_exp = 16'h0011;
`endif

    // Reset state
    rst = 1'b1; tick(); tick(); idle();
    check("rst_rdata_a", rdata_a, 16'h0000);
    check("rst_rvalid_a", W'(rvalid_a), 16'h0000);
    check("rst_rdata_b", rdata_b, 16'h0000);
    check("rst_rvalid_b", W'(rvalid_b), 16'h0000);

    // Reset clear, with 6 and 7 being out-of-range writes
    for (int i = 0; i < 8; i++) wr(AW'(i), 16'h00A5);
    rd2(3'd0, 3'd5);
    check("pre_rst_a", rdata_a, 16'h00A5);
    check("pre_rst_b", rdata_b, 16'h00A5);
    idle(); rst = 1'b1; re_a = 1'b1; re_b = 1'b1; tick();
    check("in_rst_rvalid_a", W'(rvalid_a), 16'h0000);
    check("in_rst_rdata_a", rdata_a, 16'h0000);
    for (int i = 0; i < 8; i++) begin
      rd2(AW'(i), AW'(i));
      check("clr_rdata_a", rdata_a, 16'h0000);
      check("clr_rdata_b", rdata_b, 16'h0000);
      check("clr_rvalid_a", W'(rvalid_a), 16'h0001);
    end

    // Write / readback, then same address on both ports
    wr(3'd3, 16'h003C);
    wr(3'd5, 16'h00C3);
    rd2(3'd3, 3'd5);
    check("wb_rdata_a", rdata_a, 16'h003C);
    check("wb_rdata_b", rdata_b, 16'h00C3);
    check("wb_rvalid_b", W'(rvalid_b), 16'h0001);
    rd2(3'd5, 3'd5);
    check("same_addr_a", rdata_a, 16'h00C3);
    check("same_addr_b", rdata_b, 16'h00C3);

    // Same-edge collision
    wr(3'd2, 16'h0011);
    idle(); we = 1'b1; waddr = 3'd2; wdata = 16'h0077; re_a = 1'b1; raddr_a = 3'd2; tick();
    check("coll_rdata_a", rdata_a, coll_exp);
    rd2(3'd2, 3'd2);
    check("coll_next_a", rdata_a, 16'h0077);

    // Out-of-range write never bypasses
    idle(); we = 1'b1; waddr = 3'd6; wdata = 16'h1234; re_a = 1'b1; raddr_a = 3'd6; tick();
    check("oor_byp_a", rdata_a, 16'h0000);

    // Hold / valid
    rd2(3'd3, 3'd3);
    check("hold_first_a", rdata_a, 16'h003C);
    for (int i = 0; i < 3; i++) begin
      idle(); raddr_a = AW'(i * 2); tick();
      check("hold_rdata_a", rdata_a, 16'h003C);
      check("hold_rvalid_a", W'(rvalid_a), 16'h0000);
    end

    // Out-of-range write and read
    wr(3'd7, 16'hBEEF);
    for (int i = 0; i < D; i++) begin
      rd2(AW'(i), 3'd7);
      check("oor_regs_a", rdata_a, final_tbl[i]);
      check("oor_read_b", rdata_b, 16'h0000);
      check("oor_rvalid_b", W'(rvalid_b), 16'h0001);
    end

    // Reset beats a same-edge write
    idle(); rst = 1'b1; we = 1'b1; waddr = 3'd1; wdata = 16'h00FF; tick();
    rd2(3'd1, 3'd1);
    check("rst_prio_a", rdata_a, 16'h0000);
    check("rst_prio_b", rdata_b, 16'h0000);

    idle(); tick(); tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/reg_bank.md
# reg_bank

Parametrised register bank for the datapath: DEPTH words of WIDTH bits, one synchronous write port and two independent registered read ports (A, B). It supersedes the fixed 8-way operand selector, so the ALU operand paths read from stored registers instead of from eight separate buses. Both operands are available one cycle after the address is presented, and each read port carries a valid flag.

## Interface
- WIDTH, 8, data width in bits (≥1)
- DEPTH, 8, number of registers (≥2, need not be a power of two)
- ADDR_W, $clog2(DEPTH), address width; derived, not overridden
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  reset, synchronous and active-high
- we  input  1  write enable
- waddr  input  ADDR_W  write address
- wdata  input  WIDTH  write data
- re_a  input  1  port A read request
- raddr_a  input  ADDR_W  port A read address
- rdata_a  output  WIDTH  port A read data (registered)
- rvalid_a  output  1  port A data valid (registered)
- re_b, raddr_b, rdata_b, rvalid_b  same as port A, for port B

## Operation
- Storage: DEPTH × WIDTH flip-flop array. No RAM macro.
- Write: on a rising edge with we=1 and waddr<DEPTH, mem[waddr] ← wdata. If waddr≥DEPTH, the write is dropped and no register changes.
- Read (per port, fully independent):
  - edge with re=1: rdata ← mem[raddr] if raddr<DEPTH, else 0; rvalid ← 1.
  - edge with re=0: rdata holds its previous value; rvalid ← 0.
- Ports A and B may read the same address on the same cycle. Both return identical data.
- Read and write to the same address on the same edge: behaviour depends on RB_BYPASS_EN (see Configuration). Read and write to different addresses do not interact.
- No state machine. State is the array plus the two output registers per port.

## Timing
- Reset: when rst=1 at an edge, every mem word is cleared to 0, rdata_a=rdata_b=0 and rvalid_a=rvalid_b=0. Reset takes priority over we and re on the same edge.
- Write latency: data written at edge N is visible to a read sampled at edge N+1. It appears on rdata at N+1.
- Read latency: 1 cycle. Address sampled at edge N gives data on rdata and rvalid=1 from edge N through edge N+1.
- Back-to-back reads are supported every cycle on both ports. Throughput is one read per port per cycle.
- Deasserting rst: the first edge with rst=0 performs normal write and read operations.

## Configuration
- Macro: RB_BYPASS_EN.
- Defined: a same-edge read of the address being written returns the new wdata (write-first). This applies per port. An out-of-range waddr never bypasses.
- Not defined: a same-edge read returns the old stored value (read-first). The new value is visible from the next read onward.
- All other behaviour is identical in both builds.

## Test plan
- Reset clear: write 0xA5 to regs 0..7, assert rst for one edge, read all addresses on both ports -> every rdata=0x00. During reset rvalid=0; it returns to 1 one cycle after re is asserted.
- Write/readback: write reg3=0x3C and reg5=0xC3 on consecutive edges. Next cycle read A=3, B=5 -> rdata_a=0x3C and rdata_b=0xC3 one cycle later, both rvalid=1.
- Same-edge collision: reg2 holds 0x11. On one edge write reg2=0x77 and read reg2 on A -> rdata_a=0x77 with RB_BYPASS_EN, 0x11 without. A read on the next edge returns 0x77 in both builds.
- Hold/valid: read A=3 (0x3C), then drop re_a for 3 cycles while changing raddr_a -> rdata_a stays 0x3C and rvalid_a=0 for those 3 cycles.
- Out-of-range (DEPTH=6, WIDTH=16): write addr 7 = 0xBEEF -> regs 0..5 unchanged. Read addr 7 -> rdata=0x0000 with rvalid=1.
- Reset vs write priority: assert rst and we (reg1=0xFF) on the same edge -> reading reg1 afterwards returns 0x00.
